// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time-set sequencer: mode encodings reused by the
// counter datapath and display, plus default timing constants.
package time_set_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_HOUR = 2'd1,
    MODE_MIN  = 2'd2,
    MODE_SEC  = 2'd3
  } mode_e;

  localparam int REPEAT_DELAY_DEF = 3;
  localparam int TIMEOUT_DEF      = 50;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_RUN:  next_mode = MODE_HOUR;
      MODE_HOUR: next_mode = MODE_MIN;
      MODE_MIN:  next_mode = MODE_SEC;
      default:   next_mode = MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_auto_repeat.sv
// Hold-to-repeat generator: counts 5 Hz ticks while a button is held and,
// once the delay is reached, emits one pulse per following tick.
module time_set_ctrl_auto_repeat #(
  parameter int REPEAT_DELAY = 3,
  parameter int CNT_W        = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic held_i,
  input  logic ena_5hz_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic rep_pulse_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_delay;

  assign at_delay = (cnt_q == CNT_W'(REPEAT_DELAY));

  // Counter saturates at the delay; pulses are combinational and registered by the top.
  always_comb begin
    cnt_d       = cnt_q;
    rep_pulse_o = 1'b0;
    if (clear_i || !enable_i || !held_i) begin
      cnt_d = '0;
    end else if (ena_5hz_i) begin
      if (at_delay) rep_pulse_o = 1'b1;
      else          cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Mode/adjust sequencer: turns button pulses/levels into a registered edit mode,
// adjust pulses with auto-repeat, a timekeeping hold and a field blink enable.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF,
  parameter int CNT_W        = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena_5hz,
  input  logic       mode_tick,
  input  logic       up_tick,
  input  logic       dw_tick,
  input  logic       up_held,
  input  logic       dw_held,
  output logic [1:0] select_mode,
  output logic       adj_up,
  output logic       adj_dw,
  output logic       hold_time,
  output logic       field_vis
);

  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             adj_up_q, adj_up_d, adj_dw_q, adj_dw_d;
  logic             hold_q, hold_d, vis_q, vis_d;
  logic             in_set, mode_chg, activity, rep_en, rep_up, rep_dw;
  logic             up_req, dw_req;

  assign in_set   = (mode_q != MODE_RUN);
  assign activity = mode_tick | up_tick | dw_tick | up_held | dw_held;
  assign rep_en   = in_set && !(up_held && dw_held);

  always_comb begin
    idle_d = idle_q;
    if (!in_set || activity) idle_d = '0;
    else if (ena_5hz)        idle_d = idle_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= MODE_RUN;
    else        mode_q <= mode_d;
  end

  // A mode press always wins; the timeout only fires on an idle cycle.
  always_comb begin
    mode_d = mode_q;
    if (mode_tick)                                     mode_d = next_mode(mode_q);
    else if (in_set && idle_d == CNT_W'(TIMEOUT))      mode_d = MODE_RUN;
  end

  assign mode_chg = (mode_d != mode_q);

  time_set_ctrl_auto_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .CNT_W(CNT_W)) u_rep_up (
    .clk(clk), .rst_n(rst_n), .held_i(up_held), .ena_5hz_i(ena_5hz),
    .enable_i(rep_en), .clear_i(mode_chg), .rep_pulse_o(rep_up)
  );

  time_set_ctrl_auto_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .CNT_W(CNT_W)) u_rep_dw (
    .clk(clk), .rst_n(rst_n), .held_i(dw_held), .ena_5hz_i(ena_5hz),
    .enable_i(rep_en), .clear_i(mode_chg), .rep_pulse_o(rep_dw)
  );

  assign up_req = up_tick | rep_up;
  assign dw_req = dw_tick | rep_dw;

  always_comb begin
    adj_up_d = 1'b0;
    adj_dw_d = 1'b0;
    hold_d   = (mode_d != MODE_RUN);
    vis_d    = vis_q;
    if (in_set && !mode_chg) begin
      adj_up_d = up_req & ~dw_req;
      adj_dw_d = dw_req & ~up_req;
    end
    if (mode_d == MODE_RUN || mode_chg || adj_up_d || adj_dw_d) vis_d = 1'b1;
    else if (ena_5hz)                                           vis_d = ~vis_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q   <= '0;
      adj_up_q <= 1'b0;
      adj_dw_q <= 1'b0;
      hold_q   <= 1'b0;
      vis_q    <= 1'b1;
    end else begin
      idle_q   <= idle_d;
      adj_up_q <= adj_up_d;
      adj_dw_q <= adj_dw_d;
      hold_q   <= hold_d;
      vis_q    <= vis_d;
    end
  end

  assign select_mode = mode_q;
  assign adj_up      = adj_up_q;
  assign adj_dw      = adj_dw_q;
  assign hold_time   = hold_q;
  assign field_vis   = vis_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: a behavioural model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_time_set_ctrl;

  localparam int RD = 3;
  localparam int TO = 50;

  logic clk = 1'b0;
  logic rst_n, ena_5hz, mode_tick, up_tick, dw_tick, up_held, dw_held;
  logic [1:0] select_mode;
  logic adj_up, adj_dw, hold_time, field_vis;

  int n_vec = 0;
  int n_err = 0;
  int cnt_up, cnt_dw;

  // model state
  int m_mode = 0, m_idle = 0, m_ucnt = 0, m_dcnt = 0;
  int exp_mode = 0, exp_up = 0, exp_dw = 0, exp_hold = 0, exp_vis = 1;
  int nm;
  bit chg, urep, drep, ureq, dreq, any_act;

  time_set_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena_5hz(ena_5hz), .mode_tick(mode_tick),
    .up_tick(up_tick), .dw_tick(dw_tick), .up_held(up_held), .dw_held(dw_held),
    .select_mode(select_mode), .adj_up(adj_up), .adj_dw(adj_dw),
    .hold_time(hold_time), .field_vis(field_vis)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: integer tick counters, held-duration counted without saturation.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_idle = 0; m_ucnt = 0; m_dcnt = 0;
      exp_mode = 0; exp_up = 0; exp_dw = 0; exp_hold = 0; exp_vis = 1;
    end else begin
      any_act = mode_tick | up_tick | dw_tick | up_held | dw_held;
      if (m_mode == 0 || any_act) m_idle = 0;
      else if (ena_5hz)           m_idle = m_idle + 1;
      nm = m_mode;
      if (mode_tick)                      nm = (m_mode + 1) % 4;
      else if (m_mode != 0 && m_idle >= TO) nm = 0;
      chg = (nm != m_mode);
      urep = 0; drep = 0;
      if (m_mode != 0 && !chg && up_held && !dw_held) begin
        if (ena_5hz) begin urep = (m_ucnt >= RD); m_ucnt++; end
      end else m_ucnt = 0;
      if (m_mode != 0 && !chg && dw_held && !up_held) begin
        if (ena_5hz) begin drep = (m_dcnt >= RD); m_dcnt++; end
      end else m_dcnt = 0;
      ureq = up_tick | urep;
      dreq = dw_tick | drep;
      exp_up = (m_mode != 0 && !chg && ureq && !dreq) ? 1 : 0;
      exp_dw = (m_mode != 0 && !chg && dreq && !ureq) ? 1 : 0;
      if (nm == 0 || chg || exp_up == 1 || exp_dw == 1) exp_vis = 1;
      else if (ena_5hz)                                 exp_vis = 1 - exp_vis;
      exp_mode = nm;
      exp_hold = (nm != 0) ? 1 : 0;
      m_mode = nm;
    end
  end

  always @(negedge clk) begin
    chk("cyc_mode", int'(select_mode), exp_mode);
    chk("cyc_adj_up", int'(adj_up), exp_up);
    chk("cyc_adj_dw", int'(adj_dw), exp_dw);
    chk("cyc_hold", int'(hold_time), exp_hold);
    chk("cyc_vis", int'(field_vis), exp_vis);
    chk("cyc_sep", int'(adj_up & adj_dw), 0);
  end

  task automatic step(input bit e, input bit m, input bit u, input bit d);
    ena_5hz = e; mode_tick = m; up_tick = u; dw_tick = d;
    @(negedge clk);
    ena_5hz = 1'b0; mode_tick = 1'b0; up_tick = 1'b0; dw_tick = 1'b0;
    cnt_up += int'(adj_up);
    cnt_dw += int'(adj_dw);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
    end
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; ena_5hz = 0; mode_tick = 0; up_tick = 0; dw_tick = 0;
    up_held = 0; dw_held = 0; cnt_up = 0; cnt_dw = 0;
    #2 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_mode", int'(select_mode), 0);
    chk("rst_vis", int'(field_vis), 1);
    chk("rst_hold", int'(hold_time), 0);
    chk("rst_adj", int'(adj_up | adj_dw), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // mode cycling
    step(0, 1, 0, 0); chk("cyc1_mode", int'(select_mode), 1); chk("cyc1_hold", int'(hold_time), 1);
    step(0, 1, 0, 0); chk("cyc2_mode", int'(select_mode), 2);
    step(0, 1, 0, 0); chk("cyc3_mode", int'(select_mode), 3); chk("cyc3_hold", int'(hold_time), 1);
    step(0, 1, 0, 0); chk("cyc4_mode", int'(select_mode), 0); chk("cyc4_hold", int'(hold_time), 0);

    // single adjust and collisions in SET_MIN
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(0, 0, 1, 0); chk("single_up", int'(adj_up), 1);
    step(0, 0, 0, 0); chk("single_up_end", int'(adj_up), 0);
    step(0, 0, 1, 1); chk("coll_up", int'(adj_up), 0); chk("coll_dw", int'(adj_dw), 0);
    step(0, 1, 1, 0); chk("modeprio_mode", int'(select_mode), 3); chk("modeprio_up", int'(adj_up), 0);

    // timeout in SET_SEC, restarted by a press after tick 49
    ticks(TO - 1); chk("to_49_mode", int'(select_mode), 3);
    step(0, 0, 1, 0);
    ticks(TO - 1); chk("to_restart_mode", int'(select_mode), 3);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("to_mode", int'(select_mode), 0); chk("to_hold", int'(hold_time), 0); chk("to_vis", int'(field_vis), 1);

    // blink in SET_HOUR
    step(0, 1, 0, 0); chk("blk_entry", int'(field_vis), 1);
    step(1, 0, 0, 0); chk("blk_t1", int'(field_vis), 0);
    step(0, 0, 0, 0); chk("blk_hold", int'(field_vis), 0);
    step(1, 0, 0, 0); chk("blk_t2", int'(field_vis), 1);
    step(1, 0, 0, 0); chk("blk_t3", int'(field_vis), 0);
    step(0, 0, 1, 0); chk("blk_adj_vis", int'(field_vis), 1); chk("blk_adj_up", int'(adj_up), 1);

    // auto-repeat: one press pulse plus repeats on ticks 4..10
    up_held = 1'b1; cnt_up = 0; cnt_dw = 0;
    step(0, 0, 1, 0);
    ticks(10);
    chk("rep_up_total", cnt_up, 1 + 10 - RD);
    chk("rep_dw_none", cnt_dw, 0);
    up_held = 1'b0; cnt_up = 0;
    ticks(5);
    chk("rep_released", cnt_up, 0);
    up_held = 1'b1; dw_held = 1'b1; cnt_up = 0; cnt_dw = 0;
    ticks(6);
    chk("rep_both_held", cnt_up + cnt_dw, 0);
    up_held = 1'b0; dw_held = 1'b0;

    // RUN ignores buttons and keeps the field visible
    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
    chk("run_mode", int'(select_mode), 0);
    up_held = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 0);
      chk("run_adj", int'(adj_up), 0);
      chk("run_vis", int'(field_vis), 1);
    end
    up_held = 1'b0;

    // async reset while repeating in SET_MIN
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    up_held = 1'b1;
    step(0, 0, 1, 0);
    ticks(RD + 1);
    chk("pre_rst_rep", int'(adj_up), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mode", int'(select_mode), 0);
    chk("arst_adj_up", int'(adj_up), 0);
    chk("arst_vis", int'(field_vis), 1);
    chk("arst_hold", int'(hold_time), 0);
    @(negedge clk);
    up_held = 1'b0;
    rst_n = 1'b1;
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Mode/adjust sequencer for the clock's hour/min/sec counter. It turns debounced button pulses and levels into a registered select_mode state and single-cycle adjust pulses, with hold-to-repeat and an inactivity timeout. It also produces a hold signal that freezes timekeeping while a field is being set, and a blink enable for the field being edited. It sits between the debouncers and the counting datapath, and its outputs also feed the display.

Parameters:
REPEAT_DELAY, 3, ena_5hz ticks a button must be held before auto-repeat starts (600 ms)
TIMEOUT, 50, ena_5hz ticks with no button activity before SET_* falls back to RUN (10 s)
CNT_W, 6, width of the internal tick counters; must hold TIMEOUT

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena_5hz  in  1  one-cycle tick at 5 Hz, synchronous to clk
mode_tick  in  1  debounced one-cycle pulse, mode button
up_tick  in  1  debounced one-cycle pulse, up button press
dw_tick  in  1  debounced one-cycle pulse, down button press
up_held  in  1  debounced level, up button currently pressed
dw_held  in  1  debounced level, down button currently pressed
select_mode  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC
adj_up  out  1  one-cycle increment request for the field named by select_mode
adj_dw  out  1  one-cycle decrement request for the field named by select_mode
hold_time  out  1  1 = freeze normal seconds counting
field_vis  out  1  1 = show the selected field; toggles for blink in SET_*

Behaviour:
- Reset (async, rst_n=0): select_mode=0, adj_up=0, adj_dw=0, hold_time=0, field_vis=1, all counters 0. This applies mid-operation, including during auto-repeat.
- All outputs are registered. Response appears on the clock edge after the causing input cycle (1-cycle latency).
- FSM states: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN. Each mode_tick advances one step.
- hold_time = 1 exactly when the state is not RUN.
- RUN behaviour:
  - up/dw inputs are ignored; adj_* = 0.
  - field_vis = 1.
  - Idle and repeat counters are held at 0.
- SET_* single adjust:
  - up_tick alone -> adj_up pulse for 1 cycle.
  - dw_tick alone -> adj_dw pulse for 1 cycle.
  - up_tick and dw_tick in the same cycle -> no pulse.
- Priority: mode_tick in the same cycle as up_tick or dw_tick -> the state advances and the adjust is dropped.
- Auto-repeat (independently for up and dw):
  - While held and in SET_*, the repeat counter increments on each ena_5hz.
  - Once the counter equals REPEAT_DELAY, every following ena_5hz emits one adj pulse.
  - The counter saturates at REPEAT_DELAY and clears when held drops or the state changes.
  - If up_held and dw_held are both 1, neither direction repeats.
- Pulse separation: adj_up and adj_dw are never 1 in the same cycle.
- Blink:
  - In SET_*, field_vis toggles on each ena_5hz (2.5 Hz blink).
  - field_vis is forced to 1 on state entry and on any cycle that emits an adj pulse.
- Timeout:
  - The idle counter increments on ena_5hz in SET_*.
  - It clears on any mode_tick, up_tick, dw_tick, or while up_held or dw_held is 1.
  - When it reaches TIMEOUT, the next state is RUN: select_mode=0, hold_time=0, field_vis=1.
- Mode wrap: mode_tick in SET_SEC -> RUN.
- Field-value wrap-around is owned by the datapath, not by this block.

Decomposition:
- Shared package holds:
  - State encodings MODE_RUN, MODE_HOUR, MODE_MIN, MODE_SEC as 2-bit constants, reused by the counter and display.
  - Default REPEAT_DELAY and TIMEOUT constants.
- Sub-module auto_repeat:
  - Inputs: held, ena_5hz, enable, clear.
  - Output: rep_pulse.
  - Instantiated twice, for up and dw.
- Top-level holds the FSM, idle timer, blink flop and output registers.

Test Plan:
- Reset mid-SET: with select_mode=2 and up_held repeating, drive rst_n=0 -> immediately select_mode=0, adj_up=0, field_vis=1, hold_time=0.
- Mode cycling: 4 mode_tick pulses from reset -> select_mode 1,2,3,0, each one cycle after its pulse; hold_time=1 only while in 1..3.
- Single adjust and collision:
  - In SET_MIN, up_tick -> exactly one adj_up the next cycle.
  - up_tick and dw_tick in the same cycle -> no pulse.
  - mode_tick and up_tick in the same cycle -> select_mode=3, no adj_up.
- Auto-repeat: in SET_HOUR, up_tick then up_held high for 10 ena_5hz ticks -> 1 initial pulse plus 7 repeat pulses (ticks 4..10); release -> pulses stop. With dw_held also high -> no repeats.
- Timeout: enter SET_SEC and apply no buttons -> returns to RUN one cycle after the 50th ena_5hz tick. A press at tick 49 restarts the count.
- Blink:
  - In SET_HOUR, field_vis toggles on every ena_5hz.
  - An adj pulse forces field_vis=1.
  - In RUN, field_vis stays at 1.
